mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single main-memory port between I-cache and D-cache line refills/writebacks.
//  Sits between the two caches (whose hits drive ihit/dhit) and the fixed-latency memory array.
//  Enforces the MEM_LATENCY wait and returns the line with a one-cycle done pulse.
//  D-cache wins ties; alternation after a D transaction prevents I-cache starvation.
// PARAMETERS
//  ADDR_W       32   address width, byte address, line-aligned by requester
//  LINE_W       128  cache line width in bits
//  MEM_LATENCY  5    cycles the address is held before read data is valid / write commits (>=1)
//  CNT_W        4    latency counter width; must hold MEM_LATENCY-1
// PORTS
//  clk        in   1       single clock, all state on posedge
//  reset      in   1       synchronous, active-high
//  ic_req     in   1       I-cache miss request, held until ic_done
//  ic_addr    in   ADDR_W  I-cache line address
//  ic_rdata   out  LINE_W  line returned to I-cache, valid when ic_done=1
//  ic_done    out  1       one-cycle completion pulse to I-cache
//  dc_req     in   1       D-cache request, held until dc_done
//  dc_we      in   1       1=writeback line, 0=refill
//  dc_addr    in   ADDR_W  D-cache line address
//  dc_wdata   in   LINE_W  writeback line
//  dc_rdata   out  LINE_W  line returned to D-cache, valid when dc_done=1
//  dc_done    out  1       one-cycle completion pulse to D-cache
//  mem_req    out  1       memory access active (high for all BUSY cycles)
//  mem_we     out  1       write strobe, high only in final BUSY cycle
//  mem_addr   out  ADDR_W  latched address
//  mem_wdata  out  LINE_W  latched write data
//  mem_rdata  in   LINE_W  combinational read data from memory array
//  busy       out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, every output 0, cnt=0, last_owner=I (so a first tie goes to D).
//  FSM IDLE -> BUSY -> DONE -> IDLE; owner register: I or D.
//  IDLE: only dc_req -> grant D; only ic_req -> grant I; both -> D unless last_owner=D, then I.
//   On grant: latch addr/we(I forces we=0)/wdata, owner, last_owner<=owner, cnt<=MEM_LATENCY-1, ->BUSY.
//  BUSY: mem_req=1, mem_addr/mem_wdata from latches; cnt decrements each cycle.
//   cnt==0: mem_we=latched we; if read, capture mem_rdata into owner's rdata reg; ->DONE.
//  DONE: pulse owner's done for exactly one cycle; ->IDLE. No grant is made in DONE.
//  Latency: req sampled in IDLE cycle T; BUSY T+1..T+MEM_LATENCY; done at T+MEM_LATENCY+1.
//  Earliest next grant: IDLE at T+MEM_LATENCY+2. Requester drops req in the cycle after done.
//  req dropped mid-transaction: ignored; transaction completes, done still pulses.
//  rdata regs hold last read value; writebacks never modify dc_rdata.
//  Reset mid-BUSY: abort; no done pulse, no write if before final BUSY cycle; rdata regs cleared.
//  MEM_LATENCY=1: single BUSY cycle, cnt loaded with 0.
//  Addresses/data are not checked; alignment is the requester's responsibility.
// STRUCTURE
//  mem_defs.v (shared include, like other processor headers): state codes ST_IDLE/ST_BUSY/ST_DONE,
//   owner codes OWN_I/OWN_D, default MEM_LATENCY and LINE_W defines.
//  One sub-module: mem_lat_counter (load, decrement, zero flag; CNT_W wide).
//  Arbitration choice and output muxing stay inline in mem_arbiter.
//  Keep the negedge $display trace style used by the processor blocks (state, owner, cnt).
// TESTING  (MEM_LATENCY=5)
//  I refill: ic_req=1, ic_addr=0x100 at T, mem_rdata=0xA5..A5 -> mem_req T+1..T+5, ic_done=1 only at T+6 with ic_rdata=0xA5..A5.
//  D writeback: dc_we=1, dc_addr=0x200, dc_wdata=0xDEAD.. -> mem_we=1 only at T+5, addr 0x200; dc_done at T+6; dc_rdata unchanged.
//  Tie after reset: ic_req & dc_req at T -> D first (done T+6); I granted T+7, ic_done T+13.
//  Fairness: D,D back-to-back requested with ic_req held -> order D, I, D; no two D grants in a row while ic_req is high.
//  Reset at T+3 of a D write -> no mem_we, no dc_done; busy=0 and all outputs 0 at T+4.
//  Req dropped at T+2 -> transaction still completes, done pulse at T+6, no regrant at T+7.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state codes, owner codes
// and default geometry.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_LINE_W      = 128;
  localparam int DEF_MEM_LATENCY = 5;
  localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// Memory latency down-counter: load, decrement, zero flag.
module mem_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between I-cache and D-cache refills/writebacks,
// holding the access for MEM_LATENCY cycles and pulsing done one cycle later.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int LINE_W      = DEF_LINE_W,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;
  logic              pick_d;
  logic              cnt_load, cnt_dec, cnt_zero;

  mem_lat_counter #(.CNT_W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LAT_M1),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    ic_rdata_d   = ic_rdata_q;
    dc_rdata_d   = dc_rdata_q;
    pick_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ic_req || dc_req) begin
          // D wins ties unless it owned the previous transaction
          pick_d       = dc_req && (!ic_req || last_owner_q == OWN_I);
          owner_d      = pick_d ? OWN_D : OWN_I;
          last_owner_d = pick_d ? OWN_D : OWN_I;
          addr_d       = pick_d ? dc_addr : ic_addr;
          we_d         = pick_d && dc_we;
          wdata_d      = pick_d ? dc_wdata : '0;
          cnt_load     = 1'b1;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_zero) begin
          if (!we_q) begin
            if (owner_q == OWN_D) dc_rdata_d = mem_rdata;
            else                  ic_rdata_d = mem_rdata;
          end
          state_d = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      ic_rdata_q   <= '0;
      dc_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      ic_rdata_q   <= ic_rdata_d;
      dc_rdata_q   <= dc_rdata_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign mem_req   = (state_q == ST_BUSY);
  assign mem_we    = mem_req && cnt_zero && we_q;
  assign mem_addr  = mem_req ? addr_q  : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;
  assign ic_done   = (state_q == ST_DONE) && (owner_q == OWN_I);
  assign dc_done   = (state_q == ST_DONE) && (owner_q == OWN_D);
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-timeline reference model.
module tb_mem_arbiter;

  localparam int L  = 5;
  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req, dc_req, dc_we;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] dc_wdata, mem_rdata;
  logic [LW-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic          ic_done, dc_done, mem_req, mem_we, busy;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LATENCY(L), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // environment memory (driven by DUT) and reference memory (driven by model)
  logic [LW-1:0] tb_mem  [logic [AW-1:0]];
  logic [LW-1:0] ref_mem [logic [AW-1:0]];

  // reference model: one transaction record plus arbitration history
  logic          m_act = 1'b0, m_own = 1'b0, m_we = 1'b0, m_last = 1'b0, m_can_grant = 1'b0;
  int            m_t = 0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0, m_rd_pend = '0, m_ic_rd = '0, m_dc_rd = '0;
  logic          ic_hold = 1'b0, dc_hold = 1'b0, ic_just = 1'b0, dc_just = 1'b0;

  int ic_at, dc_at, ic_cnt, dc_cnt;
  logic done_order [$];

  function automatic logic [LW-1:0] dflt(input logic [AW-1:0] a);
    return {4{a ^ 32'hC0DE_0000}};
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // negedge of a cycle: check outputs, serve memory, advance model timeline
  task automatic cycle_begin();
    int k;
    logic e_req, e_we, e_icd, e_dcd;
    @(negedge clk);
    cyc++;
    ic_just = 1'b0;
    dc_just = 1'b0;
    k     = cyc - m_t;
    e_req = m_act && k >= 1 && k <= L;
    e_we  = e_req && m_we && k == L;
    e_icd = m_act && k == L + 1 && !m_own;
    e_dcd = m_act && k == L + 1 &&  m_own;
    if (m_act && k == L + 1 && !m_we) begin
      if (m_own) m_dc_rd = m_rd_pend;
      else       m_ic_rd = m_rd_pend;
    end
    chk("busy",     busy,     m_act);
    chk("mem_req",  mem_req,  e_req);
    chk("mem_we",   mem_we,   e_we);
    chk("ic_done",  ic_done,  e_icd);
    chk("dc_done",  dc_done,  e_dcd);
    chk("ic_rdata", ic_rdata, m_ic_rd);
    chk("dc_rdata", dc_rdata, m_dc_rd);
    if (e_req) chk("mem_addr",  mem_addr,  m_addr);
    if (e_we)  chk("mem_wdata", mem_wdata, m_wdata);
    mem_rdata = tb_mem.exists(mem_addr) ? tb_mem[mem_addr] : dflt(mem_addr);
    if (mem_we === 1'b1) tb_mem[mem_addr] = mem_wdata;
    if (m_act && k == L) begin
      if (m_we) ref_mem[m_addr] = m_wdata;
      else      m_rd_pend = ref_mem.exists(m_addr) ? ref_mem[m_addr] : dflt(m_addr);
    end
    m_can_grant = !m_act;
    if (m_act && k == L + 1) m_act = 1'b0;
    // requesters hold through done, then drop for a cycle
    if (e_icd) ic_hold = 1'b1;
    else if (ic_hold) begin ic_req = 1'b0; ic_hold = 1'b0; ic_just = 1'b1; end
    if (e_dcd) dc_hold = 1'b1;
    else if (dc_hold) begin dc_req = 1'b0; dc_hold = 1'b0; dc_just = 1'b1; end
  endtask

  // apply this cycle's inputs to the model (they are sampled at the next posedge)
  task automatic cycle_end();
    logic pd;
    if (reset) begin
      m_act = 1'b0; m_last = 1'b0; m_ic_rd = '0; m_dc_rd = '0;
      ic_hold = 1'b0; dc_hold = 1'b0;
    end else if (m_can_grant && (ic_req || dc_req)) begin
      pd      = dc_req && (!ic_req || !m_last);
      m_act   = 1'b1;
      m_t     = cyc;
      m_own   = pd;
      m_last  = pd;
      m_addr  = pd ? dc_addr : ic_addr;
      m_we    = pd && dc_we;
      m_wdata = dc_wdata;
    end
  endtask

  task automatic step();
    cycle_end();
    cycle_begin();
    if (ic_done === 1'b1) begin if (ic_at < 0) ic_at = cyc; ic_cnt++; done_order.push_back(1'b0); end
    if (dc_done === 1'b1) begin if (dc_at < 0) dc_at = cyc; dc_cnt++; done_order.push_back(1'b1); end
  endtask

  task automatic clr_obs();
    ic_at = -1; dc_at = -1; ic_cnt = 0; dc_cnt = 0;
    done_order.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; ic_req = 1'b0; dc_req = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // odds of 0 disable that event; otherwise it fires with probability 1/odds
  task automatic rnd_stim(input int req_odds, input int drop_odds, input int rst_odds);
    reset = (rst_odds != 0) && ($urandom_range(0, rst_odds - 1) == 0);
    if (reset) begin ic_req = 1'b0; dc_req = 1'b0; return; end
    if (drop_odds != 0 && ic_req && m_act && !m_own && $urandom_range(0, drop_odds - 1) == 0) ic_req = 1'b0;
    if (drop_odds != 0 && dc_req && m_act &&  m_own && $urandom_range(0, drop_odds - 1) == 0) dc_req = 1'b0;
    if (req_odds != 0 && !ic_req && !ic_hold && !ic_just && !(m_act && !m_own)
        && $urandom_range(0, req_odds - 1) == 0) begin
      ic_req  = 1'b1;
      ic_addr = 32'h100 * $urandom_range(1, 6);
    end
    if (req_odds != 0 && !dc_req && !dc_hold && !dc_just && !(m_act && m_own)
        && $urandom_range(0, req_odds - 1) == 0) begin
      dc_req   = 1'b1;
      dc_we    = 1'($urandom_range(0, 1));
      dc_addr  = 32'h100 * $urandom_range(1, 6);
      dc_wdata = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  logic [LW-1:0] wd;
  int t0;

  initial begin
    reset = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
    clr_obs();
    cycle_begin();
    do_reset();
    chk("rst_mem_addr",  mem_addr,  '0);
    chk("rst_mem_wdata", mem_wdata, '0);

    // I refill of a known line
    tb_mem[32'h100] = {16{8'hA5}}; ref_mem[32'h100] = {16{8'hA5}};
    clr_obs(); ic_req = 1'b1; ic_addr = 32'h100; t0 = cyc;
    repeat (8) step();
    chk("irefill_done_cyc", ic_at, t0 + 6);
    chk("irefill_data", ic_rdata, {16{8'hA5}});

    // D writeback, then read the same line back
    wd = {4{32'hDEAD_BEEF}};
    clr_obs(); dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h200; dc_wdata = wd; t0 = cyc;
    repeat (8) step();
    chk("wb_done_cyc", dc_at, t0 + 6);
    chk("wb_rdata_kept", dc_rdata, '0);
    chk("wb_mem", tb_mem.exists(32'h200) ? tb_mem[32'h200] : '0, wd);
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h200;
    repeat (8) step();
    chk("raw_data", dc_rdata, wd);

    // tie after reset, then fairness with both requesters re-requesting
    do_reset();
    clr_obs(); t0 = cyc;
    ic_req = 1'b1; ic_addr = 32'h180; dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h280;
    repeat (40) begin rnd_stim(1, 0, 0); step(); end
    chk("tie_d_done", dc_at, t0 + 6);
    chk("tie_i_done", ic_at, t0 + 13);
    chk("fair_n", done_order.size() >= 3, 1'b1);
    if (done_order.size() >= 3) begin
      chk("fair_0", done_order[0], 1'b1);
      chk("fair_1", done_order[1], 1'b0);
      chk("fair_2", done_order[2], 1'b1);
    end
    repeat (10) step();

    // reset during BUSY of a D write
    do_reset();
    clr_obs(); dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h340; dc_wdata = {4{32'h1234_5678}};
    repeat (3) step();
    reset = 1'b1; dc_req = 1'b0;
    step();
    reset = 1'b0;
    chk("rst_busy",     busy,     1'b0);
    chk("rst_mem_req",  mem_req,  1'b0);
    chk("rst_maddr",    mem_addr, '0);
    chk("rst_no_write", tb_mem.exists(32'h340), 1'b0);
    repeat (8) step();
    chk("rst_no_done", dc_cnt, 0);

    // request dropped mid-transaction still completes once
    clr_obs(); ic_req = 1'b1; ic_addr = 32'h140; t0 = cyc;
    repeat (2) step();
    ic_req = 1'b0;
    repeat (7) step();
    chk("drop_done_cyc", ic_at, t0 + 6);
    chk("drop_done_cnt", ic_cnt, 1);

    // randomized traffic with occasional drops and resets
    repeat (1500) begin rnd_stim(3, 20, 80); step(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
